// File: rtl/axi_master_pkg.sv
`default_nettype none
// ============================================================================
// Module      : axi_master_pkg
// Description : Shared types and constants for the AXI burst master.
//               - state_t and its state constants for the master FSM
//               - BURST_INCR, the AxBURST encoding used on every request
//               - AXI_SIZE_FN, which maps a data-bus width to AxSIZE
// Revision    : 1.0  initial release
// ============================================================================
package axi_master_pkg;

  typedef logic [2:0] state_t;

  localparam state_t IDLE   = 3'd0;
  localparam state_t ADDR_R = 3'd1;
  localparam state_t DATA_R = 3'd2;
  localparam state_t ADDR_W = 3'd3;
  localparam state_t DATA_W = 3'd4;
  localparam state_t RESP_B = 3'd5;

  localparam logic [1:0] BURST_INCR = 2'b01;

  // AxSIZE = log2(bytes per beat). Widths that are not a power-of-two
  // number of bytes fall back to a size of one byte.
  function automatic logic [2:0] AXI_SIZE_FN(input int unsigned data_width);
    logic [2:0] size;
    size = 3'd0;
    for (int i = 0; i < 8; i++) begin
      if ((32'd8 << i) == data_width) begin
        size = i[2:0];
      end
    end
    return size;
  endfunction

endpackage
`default_nettype wire

// File: rtl/axi_if.sv
`default_nettype none
// ============================================================================
// Module      : axi_if
// Description : AXI4 channel bundle (AR, R, AW, W, B).
//               Modport m : initiator view (drives AR*, AW*, W*, RREADY, BREADY)
//               Modport s : target view
// Revision    : 1.0  initial release
// ============================================================================
interface axi_if #(
  parameter int unsigned ID_WIDTH   = 4,
  parameter int unsigned ADDR_WIDTH = 16,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned BYTE_WIDTH = 8
);
  logic [ID_WIDTH-1:0]              arid;
  logic [ADDR_WIDTH-1:0]            araddr;
  logic [7:0]                       arlen;
  logic [2:0]                       arsize;
  logic [1:0]                       arburst;
  logic                             arvalid;
  logic                             arready;

  logic [ID_WIDTH-1:0]              rid;
  logic [DATA_WIDTH-1:0]            rdata;
  logic [1:0]                       rresp;
  logic                             rlast;
  logic                             rvalid;
  logic                             rready;

  logic [ID_WIDTH-1:0]              awid;
  logic [ADDR_WIDTH-1:0]            awaddr;
  logic [7:0]                       awlen;
  logic [2:0]                       awsize;
  logic [1:0]                       awburst;
  logic                             awvalid;
  logic                             awready;

  logic [DATA_WIDTH-1:0]            wdata;
  logic [DATA_WIDTH/BYTE_WIDTH-1:0] wstrb;
  logic                             wlast;
  logic                             wvalid;
  logic                             wready;

  logic [ID_WIDTH-1:0]              bid;
  logic [1:0]                       bresp;
  logic                             bvalid;
  logic                             bready;

  modport m (
    output arid, araddr, arlen, arsize, arburst, arvalid,
    input  arready,
    input  rid, rdata, rresp, rlast, rvalid,
    output rready,
    output awid, awaddr, awlen, awsize, awburst, awvalid,
    input  awready,
    output wdata, wstrb, wlast, wvalid,
    input  wready,
    input  bid, bresp, bvalid,
    output bready
  );

  modport s (
    input  arid, araddr, arlen, arsize, arburst, arvalid,
    output arready,
    output rid, rdata, rresp, rlast, rvalid,
    input  rready,
    input  awid, awaddr, awlen, awsize, awburst, awvalid,
    output awready,
    input  wdata, wstrb, wlast, wvalid,
    output wready,
    output bid, bresp, bvalid,
    input  bready
  );
endinterface
`default_nettype wire

// File: rtl/axi_burst_master.sv
`default_nettype none
// ============================================================================
// Module      : axi_burst_master
// Description : Single-outstanding AXI4 initiator. Turns one client command
//               into one INCR read or write burst; beat data moves on
//               valid/ready streams on the client side.
// Ports       : clk, rst_n            clock, async active-low reset
//               cmd_*                 command handshake (write, addr, len, id)
//               wr_*                  client write-beat stream into W channel
//               rd_*                  R channel beats out to the client
//               done / err            completion pulse with error flag
//               axi_m                 AXI initiator modport
// Revision    : 1.0  initial release
// ============================================================================
module axi_burst_master
  import axi_master_pkg::*;
#(
  parameter int unsigned ID_WIDTH   = 4,
  parameter int unsigned ADDR_WIDTH = 16,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned BYTE_WIDTH = 8
) (
  input  logic                             clk,
  input  logic                             rst_n,

  input  logic                             cmd_valid,
  output logic                             cmd_ready,
  input  logic                             cmd_write,
  input  logic [ADDR_WIDTH-1:0]            cmd_addr,
  input  logic [7:0]                       cmd_len,
  input  logic [ID_WIDTH-1:0]              cmd_id,

  input  logic                             wr_valid,
  output logic                             wr_ready,
  input  logic [DATA_WIDTH-1:0]            wr_data,
  input  logic [DATA_WIDTH/BYTE_WIDTH-1:0] wr_strb,

  output logic                             rd_valid,
  input  logic                             rd_ready,
  output logic [DATA_WIDTH-1:0]            rd_data,
  output logic                             rd_last,

  output logic                             done,
  output logic                             err,

  axi_if.m                                 axi_m
);

  localparam logic [2:0] AXI_SIZE = AXI_SIZE_FN(DATA_WIDTH);

  generate
    if ((DATA_WIDTH % BYTE_WIDTH) != 0) begin : g_width_check
      $error("DATA_WIDTH must be a multiple of BYTE_WIDTH");
    end
  endgenerate

  state_t                  state_q,   state_d;
  logic [ADDR_WIDTH-1:0]   addr_q,    addr_d;
  logic [7:0]              len_q,     len_d;
  logic [ID_WIDTH-1:0]     id_q,      id_d;
  logic [7:0]              cnt_q,     cnt_d;
  logic                    err_acc_q, err_acc_d;
  logic                    done_q,    done_d;
  logic                    err_q,     err_d;

  logic in_data_r;
  logic in_data_w;
  logic cnt_zero;
  logic r_hs;
  logic w_hs;
  logic r_bad;

  assign in_data_r = (state_q == DATA_R);
  assign in_data_w = (state_q == DATA_W);
  assign cnt_zero  = (cnt_q == 8'd0);
  assign r_hs      = in_data_r & axi_m.rvalid & rd_ready;
  assign w_hs      = in_data_w & wr_valid & axi_m.wready;

  // A beat is bad if its ID is foreign or RLAST disagrees with the beat
  // counter in either direction (early or missing last).
  assign r_bad = (axi_m.rid != id_q) | (axi_m.rlast != cnt_zero);

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    len_d     = len_q;
    id_d      = id_q;
    cnt_d     = cnt_q;
    err_acc_d = err_acc_q;
    done_d    = 1'b0;
    err_d     = 1'b0;

    case (state_q)
      IDLE: begin
        if (cmd_valid) begin
          addr_d    = cmd_addr;
          len_d     = cmd_len;
          id_d      = cmd_id;
          cnt_d     = cmd_len;
          err_acc_d = 1'b0;
          state_d   = cmd_write ? ADDR_W : ADDR_R;
        end
      end

      ADDR_R: begin
        if (axi_m.arready) begin
          state_d = DATA_R;
        end
      end

      DATA_R: begin
        if (r_hs) begin
          // Completion follows the beat count only; protocol errors are
          // accumulated and reported alongside done.
          if (cnt_zero) begin
            state_d = IDLE;
            done_d  = 1'b1;
            err_d   = err_acc_q | r_bad;
          end else begin
            cnt_d     = cnt_q - 8'd1;
            err_acc_d = err_acc_q | r_bad;
          end
        end
      end

      ADDR_W: begin
        if (axi_m.awready) begin
          state_d = DATA_W;
        end
      end

      DATA_W: begin
        if (w_hs) begin
          if (cnt_zero) begin
            state_d = RESP_B;
          end else begin
            cnt_d = cnt_q - 8'd1;
          end
        end
      end

      RESP_B: begin
        if (axi_m.bvalid) begin
          state_d = IDLE;
          done_d  = 1'b1;
          err_d   = err_acc_q | (axi_m.bid != id_q);
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      addr_q    <= '0;
      len_q     <= 8'd0;
      id_q      <= '0;
      cnt_q     <= 8'd0;
      err_acc_q <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      len_q     <= len_d;
      id_q      <= id_d;
      cnt_q     <= cnt_d;
      err_acc_q <= err_acc_d;
      done_q    <= done_d;
      err_q     <= err_d;
    end
  end

  // Client side
  assign cmd_ready = (state_q == IDLE);
  assign rd_valid  = in_data_r & axi_m.rvalid;
  assign rd_data   = axi_m.rdata;
  assign rd_last   = in_data_r & axi_m.rlast;
  assign wr_ready  = in_data_w & axi_m.wready;
  assign done      = done_q;
  assign err       = err_q;

  // Address channels: valids come straight from state, never from READY.
  assign axi_m.arid    = id_q;
  assign axi_m.araddr  = addr_q;
  assign axi_m.arlen   = len_q;
  assign axi_m.arsize  = AXI_SIZE;
  assign axi_m.arburst = BURST_INCR;
  assign axi_m.arvalid = (state_q == ADDR_R);

  assign axi_m.awid    = id_q;
  assign axi_m.awaddr  = addr_q;
  assign axi_m.awlen   = len_q;
  assign axi_m.awsize  = AXI_SIZE;
  assign axi_m.awburst = BURST_INCR;
  assign axi_m.awvalid = (state_q == ADDR_W);

  // Data channels
  assign axi_m.rready  = in_data_r & rd_ready;
  assign axi_m.wdata   = wr_data;
  assign axi_m.wstrb   = wr_strb;
  assign axi_m.wlast   = in_data_w & cnt_zero;
  assign axi_m.wvalid  = in_data_w & wr_valid;
  assign axi_m.bready  = (state_q == RESP_B);

endmodule
`default_nettype wire

// File: tb/tb_axi_burst_master.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_axi_burst_master
// Description : Self-checking bench for axi_burst_master with a behavioural
//               AXI target, a reference memory and scoreboard queues.
// Revision    : 1.0  initial release
// ============================================================================
module tb_axi_burst_master;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        cmd_valid, cmd_ready, cmd_write;
  logic [15:0] cmd_addr;
  logic [7:0]  cmd_len;
  logic [3:0]  cmd_id;
  logic        wr_valid, wr_ready;
  logic [31:0] wr_data;
  logic [3:0]  wr_strb;
  logic        rd_valid, rd_ready, rd_last;
  logic [31:0] rd_data;
  logic        done, err;

  axi_if #(.ID_WIDTH(4), .ADDR_WIDTH(16), .DATA_WIDTH(32), .BYTE_WIDTH(8)) axi ();

  axi_burst_master #(.ID_WIDTH(4), .ADDR_WIDTH(16), .DATA_WIDTH(32), .BYTE_WIDTH(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_len(cmd_len), .cmd_id(cmd_id),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_data(wr_data), .wr_strb(wr_strb),
    .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_data(rd_data), .rd_last(rd_last),
    .done(done), .err(err), .axi_m(axi)
  );

  typedef struct {
    logic        write;
    logic [15:0] addr;
    logic [7:0]  len;
    logic [3:0]  id;
    logic [3:0]  resp_id;
    int          early_last;
    int          a_delay;
    logic        rd_toggle;
    logic        wr_gap;
    logic [31:0] wbase;
    logic [3:0]  strb;
  } cmd_t;

  cmd_t        cmd_q[$];
  cmd_t        cur;
  logic [32:0] exp_rd_q[$];   // {last, data}
  logic [35:0] exp_w_q[$];    // {strb, data}
  logic [35:0] wr_q[$];       // client write stream {strb, data}
  logic        exp_done_q[$]; // expected err per transaction

  logic [31:0] slv_mem [0:255];
  logic [31:0] ref_mem [0:255];

  int   n_checks = 0;
  int   n_fail   = 0;
  int   cyc = 0, accept_cyc = 0, last_hs_cyc = 0;
  int   ar_cnt = 0, aw_cnt = 0, r_beat = 0, w_beat = 0;
  bit   ar_seen, aw_seen, r_active, w_active, b_pending, wr_hs;
  logic [7:0] r_word, w_word;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got=%0h expected=%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw,
                                        input logic [3:0] s);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++) if (s[b]) r[b*8 +: 8] = nw[b*8 +: 8];
    return r;
  endfunction

  task automatic add_cmd(input logic wr, input logic [15:0] addr, input logic [7:0] len,
                         input logic [3:0] id, input logic [3:0] rid, input int early,
                         input int dly, input logic tog, input logic gap,
                         input logic [31:0] wbase, input logic [3:0] strb);
    cmd_t c;
    c.write = wr; c.addr = addr; c.len = len; c.id = id; c.resp_id = rid;
    c.early_last = early; c.a_delay = dly; c.rd_toggle = tog; c.wr_gap = gap;
    c.wbase = wbase; c.strb = strb;
    cmd_q.push_back(c);
  endtask

  // Drive all bench-owned inputs just after the active edge.
  task automatic drive();
    cmd_valid = (cmd_q.size() > 0);
    if (cmd_q.size() > 0) begin
      cmd_write = cmd_q[0].write;
      cmd_addr  = cmd_q[0].addr;
      cmd_len   = cmd_q[0].len;
      cmd_id    = cmd_q[0].id;
    end
    axi.arready = axi.arvalid && (ar_cnt >= cur.a_delay);
    axi.awready = axi.awvalid && (aw_cnt >= cur.a_delay);
    axi.rvalid  = r_active;
    axi.rid     = cur.resp_id;
    axi.rdata   = slv_mem[r_word + 8'(r_beat)];
    axi.rlast   = r_active && ((r_beat == int'(cur.len)) || (r_beat == cur.early_last));
    axi.rresp   = 2'b00;
    axi.wready  = w_active;
    axi.bvalid  = b_pending;
    axi.bid     = cur.resp_id;
    axi.bresp   = 2'b00;
    rd_ready    = cur.rd_toggle ? ((cyc % 2) == 1) : 1'b1;
    if (!wr_valid || wr_hs) begin
      wr_hs = 0;
      if (wr_q.size() > 0 && !(cur.wr_gap && ($urandom_range(0, 2) == 0))) begin
        wr_valid           = 1'b1;
        {wr_strb, wr_data} = wr_q[0];
      end else begin
        wr_valid = 1'b0;
      end
    end
  endtask

  // One clock: observe and score at the falling edge, then drive.
  task automatic cycle();
    logic [32:0] er;
    logic [35:0] ew;
    logic [7:0]  wi;
    logic [31:0] d;
    @(negedge clk);
    cyc++;

    if (done) begin
      if (exp_done_q.size() == 0) check_eq("done_spurious", done, 0);
      else begin
        check_eq("done_err", err, exp_done_q.pop_front());
        check_eq("done_latency", cyc, last_hs_cyc + 1);
        check_eq("done_cmd_ready", cmd_ready, 1);
        check_eq("rd_beats_left", exp_rd_q.size(), 0);
        check_eq("wr_beats_left", exp_w_q.size(), 0);
      end
    end

    if (cmd_valid && cmd_ready) begin
      cur = cmd_q.pop_front();
      accept_cyc = cyc;
      ar_seen = 0; aw_seen = 0; ar_cnt = 0; aw_cnt = 0; r_beat = 0; w_beat = 0;
      exp_done_q.push_back((cur.resp_id != cur.id) || (cur.early_last >= 0));
      for (int i = 0; i <= int'(cur.len); i++) begin
        wi = cur.addr[9:2] + 8'(i);
        if (cur.write) begin
          d = cur.wbase + 32'(i);
          wr_q.push_back({cur.strb, d});
          exp_w_q.push_back({cur.strb, d});
          ref_mem[wi] = merge(ref_mem[wi], d, cur.strb);
        end else begin
          exp_rd_q.push_back({(i == int'(cur.len)) || (i == cur.early_last), ref_mem[wi]});
        end
      end
    end

    if (axi.arvalid) begin
      if (!ar_seen) begin check_eq("ar_latency", cyc, accept_cyc + 1); ar_seen = 1; end
      check_eq("ar_dir", cur.write, 0);
      check_eq("araddr", axi.araddr, cur.addr);
      check_eq("arlen", axi.arlen, cur.len);
      check_eq("arid", axi.arid, cur.id);
      check_eq("arburst", axi.arburst, 2'b01);
      check_eq("arsize", axi.arsize, 3'd2);
      if (axi.arready) begin r_active = 1; r_word = cur.addr[9:2]; r_beat = 0; end
      else ar_cnt++;
    end

    if (axi.rvalid && axi.rready) begin
      if (r_beat == int'(cur.len)) begin r_active = 0; last_hs_cyc = cyc; end
      r_beat++;
    end

    if (rd_valid && rd_ready) begin
      if (exp_rd_q.size() == 0) check_eq("rd_extra", rd_valid, 0);
      else begin
        er = exp_rd_q.pop_front();
        check_eq("rd_data", rd_data, er[31:0]);
        check_eq("rd_last", rd_last, er[32]);
      end
    end

    if (axi.awvalid) begin
      if (!aw_seen) begin check_eq("aw_latency", cyc, accept_cyc + 1); aw_seen = 1; end
      check_eq("aw_dir", cur.write, 1);
      check_eq("awaddr", axi.awaddr, cur.addr);
      check_eq("awlen", axi.awlen, cur.len);
      check_eq("awid", axi.awid, cur.id);
      check_eq("awburst", axi.awburst, 2'b01);
      check_eq("awsize", axi.awsize, 3'd2);
      if (axi.awready) begin w_active = 1; w_word = cur.addr[9:2]; w_beat = 0; end
      else aw_cnt++;
    end

    if (axi.wvalid && axi.wready) begin
      check_eq("wlast", axi.wlast, w_beat == int'(cur.len));
      if (exp_w_q.size() == 0) check_eq("w_extra", axi.wvalid, 0);
      else begin
        ew = exp_w_q.pop_front();
        check_eq("wdata", axi.wdata, ew[31:0]);
        check_eq("wstrb", axi.wstrb, ew[35:32]);
      end
      slv_mem[w_word + 8'(w_beat)] = merge(slv_mem[w_word + 8'(w_beat)], axi.wdata, axi.wstrb);
      if (w_beat == int'(cur.len)) begin w_active = 0; b_pending = 1; end
      w_beat++;
    end

    if (wr_valid && wr_ready) begin
      if (wr_q.size() > 0) void'(wr_q.pop_front());
      wr_hs = 1;
    end

    if (axi.bvalid && axi.bready) begin b_pending = 0; last_hs_cyc = cyc; end

    @(posedge clk);
    #1;
    drive();
  endtask

  task automatic run_all(input int budget);
    int n;
    n = 0;
    while ((cmd_q.size() > 0 || exp_done_q.size() > 0) && n < budget) begin
      cycle();
      n++;
    end
    check_eq("timeout_pending", cmd_q.size() + exp_done_q.size(), 0);
  endtask

  task automatic clear_models();
    cmd_q.delete(); exp_rd_q.delete(); exp_w_q.delete(); wr_q.delete(); exp_done_q.delete();
    r_active = 0; w_active = 0; b_pending = 0; wr_hs = 0; wr_valid = 1'b0;
    ar_cnt = 0; aw_cnt = 0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    for (int i = 0; i < 256; i++) begin
      slv_mem[i] = {8'h5A, 8'(i), 8'hC3, ~8'(i)};
      ref_mem[i] = {8'h5A, 8'(i), 8'hC3, ~8'(i)};
    end
    slv_mem[4] = 32'hDEADBEEF;
    ref_mem[4] = 32'hDEADBEEF;
    cur = '{default: 0};
    cur.early_last = -1;
    ar_seen = 0; aw_seen = 0; r_active = 0; w_active = 0; b_pending = 0; wr_hs = 0;
    r_word = 8'd0; w_word = 8'd0;

    // Reset with live-looking inputs so gated outputs are really exercised.
    rst_n = 1'b0;
    cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = 16'h0; cmd_len = 8'h0; cmd_id = 4'h0;
    wr_valid = 1'b1; wr_data = 32'h0; wr_strb = 4'hF; rd_ready = 1'b1;
    axi.arready = 1'b1; axi.awready = 1'b1; axi.rvalid = 1'b1; axi.rlast = 1'b1;
    axi.rid = 4'h0; axi.rdata = 32'h0; axi.rresp = 2'b00;
    axi.wready = 1'b1; axi.bvalid = 1'b1; axi.bid = 4'h0; axi.bresp = 2'b00;
    repeat (2) @(posedge clk);
    #1;
    check_eq("rst_cmd_ready", cmd_ready, 1);
    check_eq("rst_done", done, 0);
    check_eq("rst_err", err, 0);
    check_eq("rst_arvalid", axi.arvalid, 0);
    check_eq("rst_awvalid", axi.awvalid, 0);
    check_eq("rst_wvalid", axi.wvalid, 0);
    check_eq("rst_wlast", axi.wlast, 0);
    check_eq("rst_rready", axi.rready, 0);
    check_eq("rst_bready", axi.bready, 0);
    check_eq("rst_rd_valid", rd_valid, 0);
    check_eq("rst_wr_ready", wr_ready, 0);
    check_eq("rst_araddr", axi.araddr, 0);
    check_eq("rst_arlen", axi.arlen, 0);
    check_eq("rst_arid", axi.arid, 0);
    clear_models();
    drive();
    rst_n = 1'b1;

    // Single-beat read
    add_cmd(0, 16'h0010, 8'd0, 4'd3, 4'd3, -1, 0, 0, 0, 32'h0, 4'hF);
    run_all(200);

    // Write burst 1..4 then back-to-back readback
    add_cmd(1, 16'h0020, 8'd3, 4'd1, 4'd1, -1, 0, 0, 0, 32'd1, 4'hF);
    add_cmd(0, 16'h0020, 8'd3, 4'd1, 4'd1, -1, 0, 0, 0, 32'h0, 4'hF);
    run_all(300);

    // Backpressure: toggled rd_ready, gapped writes, delayed address ready
    add_cmd(0, 16'h0020, 8'd7, 4'd4, 4'd4, -1, 5, 1, 0, 32'h0, 4'hF);
    add_cmd(1, 16'h0040, 8'd7, 4'd5, 4'd5, -1, 5, 0, 1, 32'hC0DE0000, 4'hF);
    add_cmd(0, 16'h0040, 8'd7, 4'd5, 4'd5, -1, 0, 1, 0, 32'h0, 4'hF);
    run_all(600);

    // Partial strobes merge into existing words
    add_cmd(1, 16'h0060, 8'd1, 4'd8, 4'd8, -1, 0, 0, 0, 32'hAABBCCDD, 4'b0101);
    add_cmd(0, 16'h0060, 8'd1, 4'd8, 4'd8, -1, 0, 0, 0, 32'h0, 4'hF);
    run_all(300);

    // Error cases: foreign BID, early RLAST, foreign RID, then a clean read
    add_cmd(1, 16'h0080, 8'd0, 4'd2, 4'd5, -1, 0, 0, 0, 32'h11112222, 4'hF);
    add_cmd(0, 16'h0020, 8'd3, 4'd6, 4'd6, 1, 0, 0, 0, 32'h0, 4'hF);
    add_cmd(0, 16'h0020, 8'd0, 4'hA, 4'hB, -1, 0, 0, 0, 32'h0, 4'hF);
    add_cmd(0, 16'h0010, 8'd0, 4'd1, 4'd1, -1, 0, 0, 0, 32'h0, 4'hF);
    run_all(400);

    // Reset in the middle of a write burst
    add_cmd(1, 16'h0100, 8'd7, 4'd7, 4'd7, -1, 0, 0, 0, 32'h00000100, 4'hF);
    n = 0;
    while (w_beat < 2 && n < 200) begin cycle(); n++; end
    check_eq("rst_mid_reached_beat2", w_beat, 2);
    rst_n = 1'b0;
    #1;
    check_eq("rst_mid_awvalid", axi.awvalid, 0);
    check_eq("rst_mid_wvalid", axi.wvalid, 0);
    check_eq("rst_mid_wlast", axi.wlast, 0);
    check_eq("rst_mid_bready", axi.bready, 0);
    check_eq("rst_mid_cmd_ready", cmd_ready, 1);
    check_eq("rst_mid_done", done, 0);
    clear_models();
    drive();
    repeat (3) cycle();
    rst_n = 1'b1;
    cycle();
    check_eq("rst_mid_no_done", done, 0);

    // Normal traffic after the reset
    add_cmd(0, 16'h0010, 8'd0, 4'd9, 4'd9, -1, 0, 0, 0, 32'h0, 4'hF);
    add_cmd(1, 16'h0200, 8'd2, 4'd3, 4'd3, -1, 2, 0, 1, 32'h7000_0000, 4'hF);
    add_cmd(0, 16'h0200, 8'd2, 4'd3, 4'd3, -1, 0, 0, 0, 32'h0, 4'hF);
    run_all(400);

    repeat (3) cycle();
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
